// File: rtl/imem_arbiter.sv
// imem_arbiter: two-port (cpu/debug) arbiter onto a combinational instruction ROM, 1-cycle read latency.
// Define IMEM_FAIR_EN to bound debug-port starvation at MAX_WAIT cycles.
module imem_arbiter #(
    parameter int DEPTH    = 128,
    parameter int MAX_WAIT = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cpu_req,
    input  logic [31:0] cpu_addr,
    output logic        cpu_gnt,
    output logic        cpu_rvalid,
    output logic [31:0] cpu_rdata,
    input  logic        dbg_req,
    input  logic [31:0] dbg_addr,
    output logic        dbg_gnt,
    output logic        dbg_rvalid,
    output logic [31:0] dbg_rdata,
    output logic [31:0] rom_addr,
    input  logic [31:0] rom_data,
    output logic        addr_err
);
    typedef enum logic [1:0] {IDLE, CPU_RD, DBG_RD} state_t;
    state_t      state, state_nxt;
    logic [31:0] addr_q, gnt_addr;
    logic        dbg_win, bad, any_gnt;
`ifdef IMEM_FAIR_EN
    localparam int CW = ($clog2(MAX_WAIT + 1) > 3) ? $clog2(MAX_WAIT + 1) : 3;
    logic [CW-1:0] wait_cnt;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) wait_cnt <= '0;
        else        wait_cnt <= (dbg_req && !dbg_gnt) ? wait_cnt + 1'b1 : '0;
    end
    assign dbg_win = dbg_req && (!cpu_req || wait_cnt == CW'(MAX_WAIT));
`else
    assign dbg_win = dbg_req && !cpu_req;
`endif
    always_comb begin
        dbg_gnt   = rst_n && dbg_win;
        cpu_gnt   = rst_n && cpu_req && !dbg_win;
        any_gnt   = cpu_gnt || dbg_gnt;
        gnt_addr  = dbg_gnt ? dbg_addr : cpu_addr;
        bad       = (gnt_addr[1:0] != 2'b00) || (gnt_addr >= 32'(DEPTH * 4));
        // Illegal accesses still present address 0 to the ROM; held address otherwise.
        rom_addr  = any_gnt ? (bad ? 32'h0 : gnt_addr) : addr_q;
        state_nxt = cpu_gnt ? CPU_RD : (dbg_gnt ? DBG_RD : IDLE);
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            addr_q    <= '0;
            cpu_rdata <= '0;
            dbg_rdata <= '0;
            addr_err  <= 1'b0;
        end else begin
            state     <= state_nxt;
            addr_q    <= rom_addr;
            cpu_rdata <= cpu_gnt ? (bad ? 32'h0 : rom_data) : cpu_rdata;
            dbg_rdata <= dbg_gnt ? (bad ? 32'h0 : rom_data) : dbg_rdata;
            addr_err  <= any_gnt && bad;
        end
    end
    assign cpu_rvalid = (state == CPU_RD);
    assign dbg_rvalid = (state == DBG_RD);
endmodule

// File: tb/tb_imem_arbiter.sv
// tb_imem_arbiter: directed self-checking bench for imem_arbiter with a behavioural ROM.
module tb_imem_arbiter;
    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        cpu_req = 1'b0, dbg_req = 1'b0;
    logic [31:0] cpu_addr = '0, dbg_addr = '0;
    logic        cpu_gnt, cpu_rvalid, dbg_gnt, dbg_rvalid, addr_err;
    logic [31:0] cpu_rdata, dbg_rdata, rom_addr, rom_data;
    int          n_cmp = 0, n_err = 0, n_rv = 0;
    logic [31:0] exp_c, exp_d;
    logic        fair, exp_dg;

    imem_arbiter dut (
        .clk(clk), .rst_n(rst_n),
        .cpu_req(cpu_req), .cpu_addr(cpu_addr), .cpu_gnt(cpu_gnt),
        .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
        .dbg_req(dbg_req), .dbg_addr(dbg_addr), .dbg_gnt(dbg_gnt),
        .dbg_rvalid(dbg_rvalid), .dbg_rdata(dbg_rdata),
        .rom_addr(rom_addr), .rom_data(rom_data), .addr_err(addr_err)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] w(input logic [31:0] i);
        return {8'hA5, i[7:0], ~i[7:0], i[7:0]};
    endfunction

    assign rom_data = w({2'b00, rom_addr[31:2]});

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
`ifdef IMEM_FAIR_EN
        fair = 1'b1;
`else
        fair = 1'b0;
`endif
        #1 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        cpu_req = 1'b1; cpu_addr = 32'd80;
        #1;
        chk("rst_cpu_gnt", cpu_gnt, 0);
        chk("rst_dbg_gnt", dbg_gnt, 0);
        chk("rst_cpu_rvalid", cpu_rvalid, 0);
        chk("rst_dbg_rvalid", dbg_rvalid, 0);
        chk("rst_cpu_rdata", cpu_rdata, 0);
        chk("rst_dbg_rdata", dbg_rdata, 0);
        chk("rst_addr_err", addr_err, 0);
        chk("rst_rom_addr", rom_addr, 0);
        // first cycle out of reset: grant immediately
        @(negedge clk); rst_n = 1'b1; #1;
        chk("first_cpu_gnt", cpu_gnt, 1);
        chk("first_rom_addr", rom_addr, 80);
        @(negedge clk); cpu_req = 1'b0; #1;
        chk("rd80_rvalid", cpu_rvalid, 1);
        chk("rd80_rdata", cpu_rdata, w(20));
        chk("rd80_err", addr_err, 0);
        chk("idle_gnt", cpu_gnt, 0);
        chk("idle_rom_hold", rom_addr, 80);
        chk("rd80_dbg_rvalid", dbg_rvalid, 0);
        @(negedge clk); #1;
        chk("rv_one_cycle", cpu_rvalid, 0);
        chk("rdata_hold", cpu_rdata, w(20));
        // contention: cpu first, debug when cpu drops
        @(negedge clk); cpu_req = 1'b1; cpu_addr = 32'd0; dbg_req = 1'b1; dbg_addr = 32'd160; #1;
        chk("cont_cpu_gnt", cpu_gnt, 1);
        chk("cont_dbg_gnt", dbg_gnt, 0);
        chk("cont_rom_addr", rom_addr, 0);
        @(negedge clk); cpu_req = 1'b0; #1;
        chk("cont_dbg_gnt2", dbg_gnt, 1);
        chk("cont_cpu_gnt2", cpu_gnt, 0);
        chk("cont_rom_addr2", rom_addr, 160);
        chk("cont_cpu_rvalid", cpu_rvalid, 1);
        chk("cont_cpu_rdata", cpu_rdata, w(0));
        @(negedge clk); dbg_req = 1'b0; #1;
        chk("cont_dbg_rvalid", dbg_rvalid, 1);
        chk("cont_dbg_rdata", dbg_rdata, w(40));
        chk("cont_cpu_rdata_hold", cpu_rdata, w(0));
        // starvation: both held for 10 cycles
        @(negedge clk); cpu_req = 1'b1; cpu_addr = 32'd4; dbg_req = 1'b1; dbg_addr = 32'd8;
        for (int k = 1; k <= 10; k++) begin
            #1;
            exp_dg = fair && (k % 5 == 0);
            chk($sformatf("starve_dbg_gnt_%0d", k), dbg_gnt, exp_dg);
            chk($sformatf("starve_cpu_gnt_%0d", k), cpu_gnt, !exp_dg);
            @(negedge clk);
        end
        cpu_req = 1'b0; dbg_req = 1'b0;
        @(negedge clk);
        // illegal debug accesses
        dbg_req = 1'b1; dbg_addr = 32'd514; #1;
        chk("ill514_gnt", dbg_gnt, 1);
        chk("ill514_rom", rom_addr, 0);
        @(negedge clk); dbg_addr = 32'd512; #1;
        chk("ill512_gnt", dbg_gnt, 1);
        chk("ill512_rom", rom_addr, 0);
        chk("ill514_rvalid", dbg_rvalid, 1);
        chk("ill514_rdata", dbg_rdata, 0);
        chk("ill514_err", addr_err, 1);
        @(negedge clk); dbg_req = 1'b0; #1;
        chk("ill512_rvalid", dbg_rvalid, 1);
        chk("ill512_rdata", dbg_rdata, 0);
        chk("ill512_err", addr_err, 1);
        @(negedge clk); #1;
        chk("err_clear", addr_err, 0);
        // alternating grants every cycle
        exp_c = cpu_rdata; exp_d = 32'h0;
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            cpu_req = (i < 8) && (i % 2 == 0); cpu_addr = 32'((i + 1) * 4);
            dbg_req = (i < 8) && (i % 2 == 1); dbg_addr = 32'((100 + i) * 4);
            #1;
            if (i > 0) begin
                if ((i - 1) % 2 == 0) exp_c = w(32'(i)); else exp_d = w(32'(99 + i));
                n_rv += int'(cpu_rvalid) + int'(dbg_rvalid);
                chk($sformatf("alt_cpu_rvalid_%0d", i), cpu_rvalid, ((i - 1) % 2 == 0));
                chk($sformatf("alt_dbg_rvalid_%0d", i), dbg_rvalid, ((i - 1) % 2 == 1));
                chk($sformatf("alt_cpu_rdata_%0d", i), cpu_rdata, exp_c);
                chk($sformatf("alt_dbg_rdata_%0d", i), dbg_rdata, exp_d);
            end
            if (i < 8) chk($sformatf("alt_gnt_%0d", i), {cpu_gnt, dbg_gnt}, (i % 2 == 0) ? 2'b10 : 2'b01);
        end
        chk("alt_rvalid_count", n_rv, 8);
        // reset with a read in flight
        @(negedge clk); cpu_req = 1'b1; cpu_addr = 32'd12; #1;
        chk("inflight_gnt", cpu_gnt, 1);
        @(negedge clk); cpu_req = 1'b0; rst_n = 1'b0; #1;
        chk("inflight_rvalid", cpu_rvalid, 0);
        chk("inflight_cpu_rdata", cpu_rdata, 0);
        chk("inflight_dbg_rdata", dbg_rdata, 0);
        chk("inflight_rom_addr", rom_addr, 0);
        chk("inflight_err", addr_err, 0);
        @(negedge clk); rst_n = 1'b1; #1;
        chk("post_rst_cpu_rvalid", cpu_rvalid, 0);
        chk("post_rst_dbg_rvalid", dbg_rvalid, 0);
        @(negedge clk); #1;
        chk("post_rst_cpu_rvalid2", cpu_rvalid, 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
